// File: rtl/inst_memory.sv
// inst_memory: memory stage of the pipeline. Commits ALU results directly,
// completes lw/sw accesses against a data memory with a ready handshake, and
// abandons an access after TIMEOUT consecutive wait cycles.
//
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   pc_in, inst_in      pc [31:2] and instruction word from execute
//   load, store         instruction is lw / sw (both set is treated as lw)
//   rd_in, rd_val_in    destination register and ALU/link result
//   mem_dout, mem_ready data memory read data and completion strobe
//   stall               combinational hold request to upstream
//   mem_rd, mem_rd_val  registered forwarding path to execute
//   pc_out, inst_out    committed instruction
//   wb_en/wb_rd/wb_val  register-file write port
//   bus_err             one-cycle pulse when an access is abandoned
module inst_memory #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:2] pc_in,
  input  logic [31:0] inst_in,
  input  logic        load,
  input  logic        store,
  input  logic [4:0]  rd_in,
  input  logic [31:0] rd_val_in,
  input  logic [31:0] mem_dout,
  input  logic        mem_ready,
  output logic        stall,
  output logic [4:0]  mem_rd,
  output logic [31:0] mem_rd_val,
  output logic [31:2] pc_out,
  output logic [31:0] inst_out,
  output logic        wb_en,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_val,
  output logic        bus_err
);

  localparam logic [3:0] TMO = 4'(TIMEOUT);

  typedef enum logic {IDLE, WAIT} state_e;

  state_e      state_q, state_d;
  logic [3:0]  wcnt_q, wcnt_d;
  logic [31:2] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic        wb_en_q, wb_en_d;
  logic [4:0]  wb_rd_q, wb_rd_d;
  logic [31:0] wb_val_q, wb_val_d;
  logic [4:0]  mem_rd_q, mem_rd_d;
  logic [31:0] mem_rd_val_q, mem_rd_val_d;
  logic        bus_err_q, bus_err_d;

  logic        mem_op;
  logic        is_store;
  logic        commit;
  logic        expire;
  logic        stall_c;

  assign mem_op   = load | store;
  assign is_store = store & ~load;

  always_comb begin
    state_d      = state_q;
    wcnt_d       = wcnt_q;
    pc_d         = pc_q;
    inst_d       = inst_q;
    wb_en_d      = 1'b0;
    wb_rd_d      = wb_rd_q;
    wb_val_d     = wb_val_q;
    bus_err_d    = 1'b0;
    stall_c      = 1'b0;
    commit       = 1'b0;
    expire       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (mem_op && !mem_ready) begin
          stall_c = 1'b1;
          state_d = WAIT;
          wcnt_d  = 4'd1;
        end else begin
          commit = 1'b1;
        end
      end
      WAIT: begin
        if (mem_ready) begin
          commit  = 1'b1;
          state_d = IDLE;
          wcnt_d  = '0;
        end else if (wcnt_q >= TMO) begin
          // Abandoned load still retires with a zero result; abandoned store
          // leaves every committed output untouched.
          expire    = 1'b1;
          commit    = ~is_store;
          bus_err_d = 1'b1;
          state_d   = IDLE;
          wcnt_d    = '0;
        end else begin
          stall_c = 1'b1;
          wcnt_d  = wcnt_q + 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
        wcnt_d  = '0;
      end
    endcase

    if (commit) begin
      pc_d   = pc_in;
      inst_d = inst_in;
      if (is_store) begin
        wb_en_d  = 1'b0;
        wb_rd_d  = '0;
        wb_val_d = '0;
      end else begin
        wb_en_d  = (rd_in != 5'd0);
        wb_rd_d  = rd_in;
        if (load) wb_val_d = expire ? '0 : mem_dout;
        else      wb_val_d = rd_val_in;
      end
    end

    mem_rd_d     = wb_en_d ? wb_rd_d  : '0;
    mem_rd_val_d = wb_en_d ? wb_val_d : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      wcnt_q       <= '0;
      pc_q         <= '0;
      inst_q       <= '0;
      wb_en_q      <= 1'b0;
      wb_rd_q      <= '0;
      wb_val_q     <= '0;
      mem_rd_q     <= '0;
      mem_rd_val_q <= '0;
      bus_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      wcnt_q       <= wcnt_d;
      pc_q         <= pc_d;
      inst_q       <= inst_d;
      wb_en_q      <= wb_en_d;
      wb_rd_q      <= wb_rd_d;
      wb_val_q     <= wb_val_d;
      mem_rd_q     <= mem_rd_d;
      mem_rd_val_q <= mem_rd_val_d;
      bus_err_q    <= bus_err_d;
    end
  end

  assign stall      = stall_c & ~rst;
  assign mem_rd     = mem_rd_q;
  assign mem_rd_val = mem_rd_val_q;
  assign pc_out     = pc_q;
  assign inst_out   = inst_q;
  assign wb_en      = wb_en_q;
  assign wb_rd      = wb_rd_q;
  assign wb_val     = wb_val_q;
  assign bus_err    = bus_err_q;

endmodule

// File: tb/tb_inst_memory.sv
// Directed bench for inst_memory with a cycle-level reference model of the
// pipeline stage's observable behaviour, compared on every falling edge.
module tb_inst_memory;

  localparam int TMO = 15;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:2] pc_in;
  logic [31:0] inst_in;
  logic        load, store;
  logic [4:0]  rd_in;
  logic [31:0] rd_val_in, mem_dout;
  logic        mem_ready;
  logic        stall;
  logic [4:0]  mem_rd;
  logic [31:0] mem_rd_val;
  logic [31:2] pc_out;
  logic [31:0] inst_out;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_val;
  logic        bus_err;

  int checks = 0;
  int errors = 0;

  inst_memory #(.TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .pc_in(pc_in), .inst_in(inst_in),
    .load(load), .store(store), .rd_in(rd_in), .rd_val_in(rd_val_in),
    .mem_dout(mem_dout), .mem_ready(mem_ready), .stall(stall),
    .mem_rd(mem_rd), .mem_rd_val(mem_rd_val), .pc_out(pc_out),
    .inst_out(inst_out), .wb_en(wb_en), .wb_rd(wb_rd), .wb_val(wb_val),
    .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  // Reference model: 'waited' is how many cycles the pending access has
  // already stalled; outputs are the values expected after each edge.
  int          waited = 0;
  logic [31:0] m_pc = 0, m_inst = 0, m_val = 0, m_fval = 0;
  logic [4:0]  m_rd = 0, m_frd = 0;
  logic        m_en = 0, m_err = 0;

  function automatic logic model_stall();
    return !rst && (load || store) && !mem_ready && (waited < TMO);
  endfunction

  always @(posedge clk) begin
    m_en  = 0;
    m_err = 0;
    if (rst) begin
      waited = 0;
      m_pc = 0; m_inst = 0; m_rd = 0; m_val = 0;
    end else if (!(load || store) || mem_ready || waited == TMO) begin
      logic timed_out;
      timed_out = (load || store) && !mem_ready;
      m_err = timed_out;
      if (!(timed_out && !load)) begin
        m_pc   = {2'b00, pc_in};
        m_inst = inst_in;
        if (store && !load) begin
          m_rd = 0; m_val = 0;
        end else begin
          m_rd  = rd_in;
          m_val = load ? (timed_out ? 32'h0 : mem_dout) : rd_val_in;
          m_en  = (rd_in != 0);
        end
      end
      waited = 0;
    end else begin
      waited = waited + 1;
    end
    m_frd  = m_en ? m_rd  : 5'd0;
    m_fval = m_en ? m_val : 32'h0;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("m.stall",   32'(stall),      32'(model_stall()));
    chk("m.pc_out",  32'(pc_out),     m_pc);
    chk("m.inst",    inst_out,        m_inst);
    chk("m.wb_en",   32'(wb_en),      32'(m_en));
    chk("m.wb_rd",   32'(wb_rd),      32'(m_rd));
    chk("m.wb_val",  wb_val,          m_val);
    chk("m.mem_rd",  32'(mem_rd),     32'(m_frd));
    chk("m.mem_val", mem_rd_val,      m_fval);
    chk("m.bus_err", 32'(bus_err),    32'(m_err));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:2] pc, input logic [31:0] inst,
                       input logic ld, input logic st, input logic [4:0] rd,
                       input logic [31:0] val, input logic [31:0] dout,
                       input logic rdy);
    pc_in = pc; inst_in = inst; load = ld; store = st; rd_in = rd;
    rd_val_in = val; mem_dout = dout; mem_ready = rdy;
  endtask

  task automatic bubble();
    drive(30'h0, 32'h0, 0, 0, 5'd0, 32'h0, 32'h0, 0);
  endtask

  // Counts stall-high cycles until stall drops, bounded.
  task automatic count_stalls(input string name, output int n);
    n = 0;
    #1;
    while (stall === 1'b1 && n < 40) begin
      n++;
      tick();
      #1;
    end
    if (n >= 40) begin
      errors++;
      checks++;
      $display("FAIL %s: stall never released after %0d cycles", name, n);
    end
  endtask

  int n;

  initial begin
    rst = 1;
    drive(30'h1, 32'h1, 1, 0, 5'd1, 32'h1, 32'h1, 0);
    #1;
    chk("rst.stall", 32'(stall), 0);
    tick(); tick();
    chk("rst.wb_en", 32'(wb_en), 0);
    chk("rst.pc", 32'(pc_out), 0);
    chk("rst.wb_val", wb_val, 0);
    rst = 0;

    // ALU op
    drive(30'h100, 32'h00500293, 0, 0, 5'd5, 32'h12345678, 32'h0, 0);
    tick();
    chk("alu.wb_en", 32'(wb_en), 1);
    chk("alu.wb_rd", 32'(wb_rd), 5);
    chk("alu.wb_val", wb_val, 32'h12345678);
    chk("alu.mem_rd", 32'(mem_rd), 5);
    chk("alu.mem_val", mem_rd_val, 32'h12345678);
    chk("alu.pc", 32'(pc_out), 32'h100);

    // lw hit
    drive(30'h101, 32'h00002183, 1, 0, 5'd3, 32'h0, 32'hCAFEBABE, 1);
    #1 chk("lw1.stall", 32'(stall), 0);
    tick();
    chk("lw1.wb_val", wb_val, 32'hCAFEBABE);
    chk("lw1.wb_en", 32'(wb_en), 1);

    // lw with three wait cycles
    drive(30'h102, 32'h00002383, 1, 0, 5'd7, 32'h0, 32'hA5A5A5A5, 0);
    for (int i = 0; i < 3; i++) begin
      #1 chk("lw3.stall", 32'(stall), 1);
      tick();
      chk("lw3.wb_en", 32'(wb_en), 0);
    end
    mem_ready = 1;
    #1 chk("lw3.stall_rel", 32'(stall), 0);
    tick();
    chk("lw3.wb_val", wb_val, 32'hA5A5A5A5);
    chk("lw3.wb_en", 32'(wb_en), 1);
    bubble();
    tick();
    chk("bubble.wb_en", 32'(wb_en), 0);
    chk("bubble.inst", inst_out, 0);

    // sw that never completes
    drive(30'h103, 32'h00112023, 0, 1, 5'd0, 32'h0, 32'h0, 0);
    count_stalls("sw_to", n);
    chk("sw_to.stalls", 32'(n), 15);
    tick();
    chk("sw_to.bus_err", 32'(bus_err), 1);
    chk("sw_to.wb_en", 32'(wb_en), 0);
    bubble();
    tick();
    chk("sw_to.err_once", 32'(bus_err), 0);

    // lw that times out commits zero
    drive(30'h104, 32'h00002103, 1, 0, 5'd2, 32'h0, 32'hDEADBEEF, 0);
    count_stalls("lw_to", n);
    chk("lw_to.stalls", 32'(n), 15);
    tick();
    chk("lw_to.bus_err", 32'(bus_err), 1);
    chk("lw_to.wb_en", 32'(wb_en), 1);
    chk("lw_to.wb_val", wb_val, 0);

    // ready arrives exactly at the timeout cycle
    drive(30'h105, 32'h00002403, 1, 0, 5'd8, 32'h0, 32'h0BADF00D, 0);
    for (int i = 0; i < 15; i++) tick();
    mem_ready = 1;
    #1 chk("edge.stall", 32'(stall), 0);
    tick();
    chk("edge.bus_err", 32'(bus_err), 0);
    chk("edge.wb_val", wb_val, 32'h0BADF00D);

    // rd=0 ALU op is never written or forwarded
    drive(30'h106, 32'h00000013, 0, 0, 5'd0, 32'hFFFFFFFF, 32'h0, 0);
    tick();
    chk("r0.wb_en", 32'(wb_en), 0);
    chk("r0.mem_rd", 32'(mem_rd), 0);
    chk("r0.mem_val", mem_rd_val, 0);

    // load and store together behave as a load
    drive(30'h107, 32'h0, 1, 1, 5'd6, 32'h0, 32'h00000077, 1);
    tick();
    chk("ldst.wb_en", 32'(wb_en), 1);
    chk("ldst.wb_val", wb_val, 32'h77);

    // store hit clears write port
    drive(30'h108, 32'h00112023, 0, 1, 5'd9, 32'h99, 32'h0, 1);
    tick();
    chk("sw.wb_rd", 32'(wb_rd), 0);
    chk("sw.pc", 32'(pc_out), 32'h108);

    // reset in the second wait cycle of a lw
    drive(30'h109, 32'h00002483, 1, 0, 5'd9, 32'h0, 32'h11111111, 0);
    tick(); tick();
    rst = 1;
    #1 chk("rstw.stall", 32'(stall), 0);
    tick();
    chk("rstw.wb_en", 32'(wb_en), 0);
    chk("rstw.bus_err", 32'(bus_err), 0);
    chk("rstw.pc", 32'(pc_out), 0);
    rst = 0;
    drive(30'h10A, 32'h00400213, 0, 0, 5'd4, 32'h55, 32'h0, 0);
    tick();
    chk("post.wb_en", 32'(wb_en), 1);
    chk("post.wb_val", wb_val, 32'h55);
    bubble();
    tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
